// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
// Each channel owns an active divisor, a shadow divisor, a wrap counter and a
// pending flag. A channel that is running takes a new divisor at its next wrap
// so that the current half-period always finishes. A restart write, or a write
// to a channel that is not counting, takes effect on the very next edge.
module clk_div_multi #(
  parameter int CH      = 4,
  parameter int WIDTH   = 27,
  parameter int DEF_DIV = 25_000_000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CH-1:0]    enable_i,
  input  logic             cfg_we_i,
  input  logic [2:0]       cfg_ch_i,
  input  logic [WIDTH-1:0] cfg_div_i,
  input  logic             cfg_restart_i,
  output logic [CH-1:0]    clk_out_o,
  output logic [CH-1:0]    tick_o,
  output logic [CH-1:0]    pending_o
);

  localparam logic [WIDTH-1:0] DEF_DIV_W = WIDTH'(DEF_DIV);
  localparam logic [WIDTH-1:0] ZERO_W    = '0;
  localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);
  localparam logic [3:0]       CH_W      = 4'(CH);

  logic [WIDTH-1:0] act_q [CH];
  logic [WIDTH-1:0] act_d [CH];
  logic [WIDTH-1:0] shd_q [CH];
  logic [WIDTH-1:0] shd_d [CH];
  logic [WIDTH-1:0] cnt_q [CH];
  logic [WIDTH-1:0] cnt_d [CH];

  logic [CH-1:0] clk_q,  clk_d;
  logic [CH-1:0] tick_q, tick_d;
  logic [CH-1:0] pend_q, pend_d;

  logic [CH-1:0] sel;
  logic [CH-1:0] run;
  logic [CH-1:0] wrap;
  logic [CH-1:0] apply_now;

  // Address decode: one-hot channel select; indices beyond CH select nothing.
  always_comb begin
    sel = '0;
    if (cfg_we_i && ({1'b0, cfg_ch_i} < CH_W)) begin
      for (int i = 0; i < CH; i++) begin
        if (cfg_ch_i == 3'(i)) begin
          sel[i] = 1'b1;
        end
      end
    end
  end

  // Per-channel status: counting, at terminal count, or taking a write at once.
  // A stalled (D=0) or disabled channel has no wrap to wait for, so a write
  // to it is applied immediately.
  always_comb begin
    run       = '0;
    wrap      = '0;
    apply_now = '0;
    for (int i = 0; i < CH; i++) begin
      run[i]       = enable_i[i] && (act_q[i] != ZERO_W);
      wrap[i]      = run[i] && (cnt_q[i] == (act_q[i] - ONE_W));
      apply_now[i] = sel[i] && (cfg_restart_i || !run[i]);
    end
  end

  // Next-state logic for every channel.
  always_comb begin
    clk_d  = clk_q;
    tick_d = '0;
    pend_d = pend_q;
    for (int i = 0; i < CH; i++) begin
      act_d[i] = act_q[i];
      shd_d[i] = shd_q[i];
      cnt_d[i] = cnt_q[i];

      if (apply_now[i]) begin
        // Immediate load: any wrap on this edge is swallowed. Only an explicit
        // restart resets the output phase; a passive channel keeps its level.
        act_d[i]  = cfg_div_i;
        shd_d[i]  = cfg_div_i;
        cnt_d[i]  = ZERO_W;
        pend_d[i] = 1'b0;
        if (cfg_restart_i) begin
          clk_d[i] = 1'b0;
        end
      end else begin
        if (run[i]) begin
          if (wrap[i]) begin
            cnt_d[i]  = ZERO_W;
            tick_d[i] = 1'b1;
            clk_d[i]  = ~clk_q[i];
            if (pend_q[i]) begin
              act_d[i]  = shd_q[i];
              pend_d[i] = 1'b0;
            end
          end else begin
            cnt_d[i] = cnt_q[i] + ONE_W;
          end
        end else if (act_q[i] == ZERO_W) begin
          cnt_d[i] = ZERO_W;
        end

        // Deferred write. If it lands on a wrap edge, the previous shadow (if
        // any) is what gets promoted; the new value waits for the next wrap.
        if (sel[i]) begin
          shd_d[i]  = cfg_div_i;
          pend_d[i] = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset to the default divisor.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_q  <= '0;
      tick_q <= '0;
      pend_q <= '0;
      for (int i = 0; i < CH; i++) begin
        act_q[i] <= DEF_DIV_W;
        shd_q[i] <= DEF_DIV_W;
        cnt_q[i] <= ZERO_W;
      end
    end else begin
      clk_q  <= clk_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
      for (int i = 0; i < CH; i++) begin
        act_q[i] <= act_d[i];
        shd_q[i] <= shd_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with CH=2, WIDTH=8, DEF_DIV=4.
module tb_clk_div_multi;
  localparam int CH      = 2;
  localparam int WIDTH   = 8;
  localparam int DEF_DIV = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [CH-1:0]    enable = '0;
  logic             cfg_we = 1'b0;
  logic [2:0]       cfg_ch = '0;
  logic [WIDTH-1:0] cfg_div = '0;
  logic             cfg_restart = 1'b0;
  logic [CH-1:0]    clk_out;
  logic [CH-1:0]    tick;
  logic [CH-1:0]    pending;

  int errors = 0;
  int checks = 0;

  clk_div_multi #(.CH(CH), .WIDTH(WIDTH), .DEF_DIV(DEF_DIV)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .cfg_we_i(cfg_we),
    .cfg_ch_i(cfg_ch), .cfg_div_i(cfg_div), .cfg_restart_i(cfg_restart),
    .clk_out_o(clk_out), .tick_o(tick), .pending_o(pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_write(input logic [2:0] ch, input logic [WIDTH-1:0] div, input logic rs);
    cfg_we = 1'b1; cfg_ch = ch; cfg_div = div; cfg_restart = rs;
  endtask

  task automatic test_reset();
    logic [1:0] et, ec;
    enable = 2'b11;
    #2 rst_n = 1'b0;
    #2;
    checks++; if (tick !== 2'b00) begin errors++; $display("FAIL rst_tick got=%b exp=00", tick); end
    checks++; if (clk_out !== 2'b00) begin errors++; $display("FAIL rst_clk got=%b exp=00", clk_out); end
    checks++; if (pending !== 2'b00) begin errors++; $display("FAIL rst_pend got=%b exp=00", pending); end
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      et = (k % 4 == 0) ? 2'b11 : 2'b00;
      ec = ((k / 4) % 2 == 1) ? 2'b11 : 2'b00;
      checks++; if (tick !== et) begin errors++; $display("FAIL def_tick k=%0d got=%b exp=%b", k, tick, et); end
      checks++; if (clk_out !== ec) begin errors++; $display("FAIL def_clk k=%0d got=%b exp=%b", k, clk_out, ec); end
    end
  endtask

  task automatic test_shadow();
    logic [1:0] et, ec;
    do_reset();
    step();                         // k=1, count 1
    set_write(3'd0, 8'd2, 1'b0);
    step();                         // k=2
    cfg_we = 1'b0;
    checks++; if (pending !== 2'b01) begin errors++; $display("FAIL shd_pend_set got=%b exp=01", pending); end
    step();                         // k=3
    checks++; if (pending !== 2'b01) begin errors++; $display("FAIL shd_pend_hold got=%b exp=01", pending); end
    checks++; if (tick !== 2'b00) begin errors++; $display("FAIL shd_tick3 got=%b exp=00", tick); end
    step();                         // k=4: wrap with old divisor
    checks++; if (tick !== 2'b11) begin errors++; $display("FAIL shd_wrap_tick got=%b exp=11", tick); end
    checks++; if (pending !== 2'b00) begin errors++; $display("FAIL shd_pend_clr got=%b exp=00", pending); end
    checks++; if (clk_out !== 2'b11) begin errors++; $display("FAIL shd_wrap_clk got=%b exp=11", clk_out); end
    for (int k = 5; k <= 16; k++) begin
      step();
      et[0] = (k % 2 == 0);
      ec[0] = (((k - 4) / 2) % 2 == 0);
      et[1] = (k % 4 == 0);
      ec[1] = ((k / 4) % 2 == 1);
      checks++; if (tick !== et) begin errors++; $display("FAIL shd_tick k=%0d got=%b exp=%b", k, tick, et); end
      checks++; if (clk_out !== ec) begin errors++; $display("FAIL shd_clk k=%0d got=%b exp=%b", k, clk_out, ec); end
    end
  endtask

  task automatic test_restart();
    logic [1:0] et, ec;
    do_reset();
    for (int k = 1; k <= 5; k++) step();
    set_write(3'd1, 8'd3, 1'b1);
    step();                         // k=6
    cfg_we = 1'b0;
    checks++; if (clk_out !== 2'b01) begin errors++; $display("FAIL rs_clk_clear got=%b exp=01", clk_out); end
    checks++; if (tick[1] !== 1'b0) begin errors++; $display("FAIL rs_tick_clear got=%b exp=0", tick[1]); end
    checks++; if (pending !== 2'b00) begin errors++; $display("FAIL rs_pend got=%b exp=00", pending); end
    for (int k = 7; k <= 14; k++) begin
      step();
      et[0] = (k % 4 == 0);
      ec[0] = ((k / 4) % 2 == 1);
      et[1] = (k >= 9) && ((k - 9) % 3 == 0);
      ec[1] = (k >= 9) && (((k - 9) / 3) % 2 == 0);
      checks++; if (tick !== et) begin errors++; $display("FAIL rs_tick k=%0d got=%b exp=%b", k, tick, et); end
      checks++; if (clk_out !== ec) begin errors++; $display("FAIL rs_clk k=%0d got=%b exp=%b", k, clk_out, ec); end
    end
    set_write(3'd1, 8'd3, 1'b1);    // lands on ch1 terminal count
    step();                         // k=15
    cfg_we = 1'b0;
    checks++; if (tick[1] !== 1'b0) begin errors++; $display("FAIL rs_wrap_suppress got=%b exp=0", tick[1]); end
    step(); step(); step();         // k=18
    checks++; if (tick !== 2'b10) begin errors++; $display("FAIL rs_after_tick got=%b exp=10", tick); end
    checks++; if (clk_out[1] !== 1'b1) begin errors++; $display("FAIL rs_after_clk got=%b exp=1", clk_out[1]); end
  endtask

  task automatic test_enable();
    do_reset();
    step(); step();                 // count 2
    enable = 2'b10;
    for (int k = 3; k <= 12; k++) begin
      step();
      checks++; if (tick[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
        errors++; $display("FAIL en_hold k=%0d tick0=%b clk0=%b exp 0/0", k, tick[0], clk_out[0]);
      end
      checks++; if (tick[1] !== (k % 4 == 0)) begin
        errors++; $display("FAIL en_ch1 k=%0d got=%b exp=%b", k, tick[1], (k % 4 == 0));
      end
    end
    enable = 2'b11;
    step();
    checks++; if (tick[0] !== 1'b0) begin errors++; $display("FAIL en_resume1 got=%b exp=0", tick[0]); end
    step();
    checks++; if (tick[0] !== 1'b1 || clk_out[0] !== 1'b1) begin
      errors++; $display("FAIL en_resume2 tick0=%b clk0=%b exp 1/1", tick[0], clk_out[0]);
    end
  endtask

  task automatic test_zero_one();
    do_reset();
    step();
    set_write(3'd0, 8'd0, 1'b1);
    step();                         // k=2
    cfg_we = 1'b0;
    for (int k = 3; k <= 22; k++) begin
      step();
      checks++; if (tick[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
        errors++; $display("FAIL d0_stall k=%0d tick0=%b clk0=%b exp 0/0", k, tick[0], clk_out[0]);
      end
    end
    set_write(3'd0, 8'd1, 1'b1);
    step();                         // k=23
    cfg_we = 1'b0;
    checks++; if (tick[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
      errors++; $display("FAIL d1_restart tick0=%b clk0=%b exp 0/0", tick[0], clk_out[0]);
    end
    for (int k = 24; k <= 34; k++) begin
      step();
      checks++; if (tick[0] !== 1'b1) begin errors++; $display("FAIL d1_tick k=%0d got=%b exp=1", k, tick[0]); end
      checks++; if (clk_out[0] !== ((k - 24) % 2 == 0)) begin
        errors++; $display("FAIL d1_clk k=%0d got=%b exp=%b", k, clk_out[0], ((k - 24) % 2 == 0));
      end
    end
    enable = 2'b10;
    step();                         // k=35, disabled, clk0 held high
    checks++; if (tick[0] !== 1'b0 || clk_out[0] !== 1'b1) begin
      errors++; $display("FAIL dis_hold tick0=%b clk0=%b exp 0/1", tick[0], clk_out[0]);
    end
    set_write(3'd0, 8'd5, 1'b0);
    step();                         // k=36, immediate load, phase kept
    cfg_we = 1'b0;
    checks++; if (pending[0] !== 1'b0 || clk_out[0] !== 1'b1) begin
      errors++; $display("FAIL dis_write pend0=%b clk0=%b exp 0/1", pending[0], clk_out[0]);
    end
    enable = 2'b11;
    for (int k = 37; k <= 40; k++) begin
      step();
      checks++; if (tick[0] !== 1'b0) begin errors++; $display("FAIL dis_d5 k=%0d got=%b exp=0", k, tick[0]); end
    end
    step();                         // k=41
    checks++; if (tick[0] !== 1'b1 || clk_out[0] !== 1'b0) begin
      errors++; $display("FAIL dis_d5_wrap tick0=%b clk0=%b exp 1/0", tick[0], clk_out[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] et, ec;
    do_reset();
    step();
    set_write(3'd0, 8'd2, 1'b0);
    step();
    cfg_we = 1'b0;
    step();                         // count 3, pending0 set
    checks++; if (pending !== 2'b01) begin errors++; $display("FAIL rm_pre_pend got=%b exp=01", pending); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (tick !== 2'b00 || clk_out !== 2'b00 || pending !== 2'b00) begin
      errors++; $display("FAIL rm_async tick=%b clk=%b pend=%b exp all 0", tick, clk_out, pending);
    end
    step();
    rst_n = 1'b1;
    set_write(3'd2, 8'd1, 1'b1);    // out-of-range channel
    for (int k = 1; k <= 8; k++) begin
      step();
      cfg_we = 1'b0;
      et = (k % 4 == 0) ? 2'b11 : 2'b00;
      ec = ((k / 4) % 2 == 1) ? 2'b11 : 2'b00;
      checks++; if (tick !== et || clk_out !== ec || pending !== 2'b00) begin
        errors++; $display("FAIL rm_after k=%0d tick=%b clk=%b pend=%b exp %b/%b/00", k, tick, clk_out, pending, et, ec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_shadow();
    test_restart();
    test_enable();
    test_zero_one();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
